// File: rtl/pwm_audio_rx.sv
// rtl/pwm_audio_rx.sv - 1-bit PWM/SDM audio demodulator with valid/ready sample output
//
// Counts ones over a fixed window of 2^WIN_LOG2 enabled clocks. Both PWM and
// first-order sigma-delta streams carry exactly `value` high cycles per
// 256-cycle period, so one integrator recovers either modulation.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   ena        clock enable; low freezes every register (handshake still honoured)
//   bit_in     asynchronous PWM/SDM bitstream
//   out_ready  consumer accepts the sample when out_valid && out_ready
//   ovr_clr    synchronous clear of ovr_flag
//   out_sample recovered sample (WIN_LOG2 bits)
//   out_valid  sample available
//   ovr_flag   sticky: a sample was overwritten before being accepted
//   locked     high once the synchronizer has been flushed (RUN state)
module pwm_audio_rx #(
    parameter int WIN_LOG2    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                bit_in,
    input  logic                out_ready,
    input  logic                ovr_clr,
    output logic [WIN_LOG2-1:0] out_sample,
    output logic                out_valid,
    output logic                ovr_flag,
    output logic                locked
);

    localparam int SCW = $clog2(SYNC_STAGES + 1);

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SCW-1:0]         scnt_q, scnt_d;
    logic [WIN_LOG2-1:0]    win_q, win_d;
    logic [WIN_LOG2:0]      ones_q, ones_d;
    logic [WIN_LOG2-1:0]    sample_q, sample_d;
    logic                   valid_q, valid_d;
    logic                   ovr_q, ovr_d;

    logic                   sbit;
    logic                   close;
    logic [WIN_LOG2:0]      total;

    assign sbit = sync_q[SYNC_STAGES-1];
    // The extra bit of the ones counter holds the all-ones case (2^WIN_LOG2).
    assign total = ones_q + {{WIN_LOG2{1'b0}}, sbit};

    always_comb begin
        state_d  = state_q;
        sync_d   = sync_q;
        scnt_d   = scnt_q;
        win_d    = win_q;
        ones_d   = ones_q;
        sample_d = sample_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        close    = 1'b0;

        if (ena) begin
            sync_d = {sync_q[SYNC_STAGES-2:0], bit_in};
            case (state_q)
                ST_SYNC: begin
                    // Wait until reset-time zeros have left the synchronizer.
                    if (scnt_q == SCW'(SYNC_STAGES - 1)) begin
                        state_d = ST_RUN;
                        win_d   = '0;
                        ones_d  = '0;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    win_d  = win_q + 1'b1;
                    ones_d = total;
                    if (&win_q) begin
                        close  = 1'b1;
                        ones_d = '0;
                    end
                end
                default: state_d = ST_SYNC;
            endcase
        end

        // A close wins over an accept: the old sample is treated as consumed
        // when out_ready is high, and overwritten (overrun) when it is low.
        if (close) begin
            sample_d = total[WIN_LOG2] ? {WIN_LOG2{1'b1}} : total[WIN_LOG2-1:0];
            valid_d  = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        if (close && valid_q && !out_ready) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_SYNC;
            sync_q   <= '0;
            scnt_q   <= '0;
            win_q    <= '0;
            ones_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            scnt_q   <= scnt_d;
            win_q    <= win_d;
            ones_q   <= ones_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign out_sample = sample_q;
    assign out_valid  = valid_q;
    assign ovr_flag   = ovr_q;
    assign locked     = (state_q == ST_RUN);

endmodule

// File: tb/tb_pwm_audio_rx.sv
// tb/tb_pwm_audio_rx.sv - self-checking bench for pwm_audio_rx
module tb_pwm_audio_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       bit_in;
    logic       out_ready;
    logic       ovr_clr;
    logic [7:0] out_sample;
    logic       out_valid;
    logic       ovr_flag;
    logic       locked;

    int errors = 0;
    int checks = 0;

    logic [7:0] pwm_cnt = 8'd37;
    logic [8:0] sdm_acc = 9'd0;

    pwm_audio_rx #(.WIN_LOG2(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .bit_in    (bit_in),
        .out_ready (out_ready),
        .ovr_clr   (ovr_clr),
        .out_sample(out_sample),
        .out_valid (out_valid),
        .ovr_flag  (ovr_flag),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    mode;   // 0 = PWM, 1 = SDM
        int    value;
        int    exp;
        string name;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic b, input logic e);
        bit_in = b;
        ena    = e;
        @(posedge clk);
        #1;
        pwm_cnt = pwm_cnt + 8'd1;
    endtask

    task automatic stream_tick(input int mode, input int val);
        logic b;
        if (mode == 0) begin
            b = (val > int'(pwm_cnt));
        end else begin
            sdm_acc = {1'b0, sdm_acc[7:0]} + 9'(val);
            b = sdm_acc[8];
        end
        tick(b, 1'b1);
    endtask

    // Release from reset with constant 1 input: locks after 2 cycles and the
    // first (saturated) sample lands on the 258th enabled edge.
    task automatic check_startup(input string tag);
        tick(1'b1, 1'b1);
        check({tag, " locked after 1"}, locked, 0);
        check({tag, " valid after 1"}, out_valid, 0);
        tick(1'b1, 1'b1);
        check({tag, " locked after 2"}, locked, 1);
        repeat (255) tick(1'b1, 1'b1);
        check({tag, " valid after 257"}, out_valid, 0);
        tick(1'b1, 1'b1);
        check({tag, " valid after 258"}, out_valid, 1);
        check({tag, " saturated sample"}, out_sample, 255);
    endtask

    initial begin
        int nvalid;
        int s;

        vecs[0] = '{0, 100, 100, "pwm 100"};
        vecs[1] = '{0,   0,   0, "pwm 0"};
        vecs[2] = '{0, 255, 255, "pwm 255"};
        vecs[3] = '{0, 128, 128, "pwm 128"};
        vecs[4] = '{1,  37,  37, "sdm 37"};
        vecs[5] = '{1, 200, 200, "sdm 200"};
        vecs[6] = '{1,   1,   1, "sdm 1"};

        rst_n = 1'b0; ena = 1'b1; bit_in = 1'b1; out_ready = 1'b1; ovr_clr = 1'b0;
        repeat (3) tick(1'b1, 1'b1);
        check("reset sample", out_sample, 0);
        check("reset valid", out_valid, 0);
        check("reset ovr", ovr_flag, 0);
        check("reset locked", locked, 0);
        rst_n = 1'b1;
        check_startup("startup");

        // Each vector spans two aligned windows: the first is a blend with the
        // previous stream, the second must be exact.
        foreach (vecs[i]) begin
            nvalid = 0;
            for (int t = 0; t < 512; t++) begin
                stream_tick(vecs[i].mode, vecs[i].value);
                if (out_valid) nvalid++;
            end
            check({vecs[i].name, " sample"}, out_sample, vecs[i].exp);
            check({vecs[i].name, " valid pulses"}, nvalid, 2);
            check({vecs[i].name, " ovr"}, ovr_flag, 0);
        end

        // SDM step mid-window
        repeat (256) stream_tick(1, 37);
        repeat (128) stream_tick(1, 37);
        repeat (128) stream_tick(1, 200);
        s = out_sample;
        checks++;
        if (!(s > 37 && s < 200)) begin
            errors++;
            $display("FAIL sdm blend: got %0d expected between 37 and 200", s);
        end
        repeat (256) stream_tick(1, 200);
        check("sdm after step", out_sample, 200);

        // Handshake and overrun
        repeat (256) stream_tick(0, 50);
        stream_tick(0, 50);
        check("hs consumed", out_valid, 0);
        out_ready = 1'b0;
        repeat (255) stream_tick(0, 50);
        check("hs close1 valid", out_valid, 1);
        check("hs close1 sample", out_sample, 50);
        check("hs close1 ovr", ovr_flag, 0);
        repeat (256) stream_tick(0, 50);
        check("hs close2 valid", out_valid, 1);
        check("hs close2 sample", out_sample, 50);
        check("hs close2 ovr", ovr_flag, 1);
        ovr_clr = 1'b1;
        stream_tick(0, 50);
        ovr_clr = 1'b0;
        check("ovr cleared", ovr_flag, 0);
        check("valid held after clr", out_valid, 1);
        repeat (254) stream_tick(0, 50);
        out_ready = 1'b1;
        stream_tick(0, 50);
        check("close+accept valid", out_valid, 1);
        check("close+accept ovr", ovr_flag, 0);
        check("close+accept sample", out_sample, 50);
        stream_tick(0, 50);
        check("accept after close", out_valid, 0);

        // Realign on zeros: second window is exactly 0
        repeat (255) tick(1'b0, 1'b1);
        repeat (256) tick(1'b0, 1'b1);
        check("zero window", out_sample, 0);

        // ena freeze mid-window
        repeat (100) tick(1'b0, 1'b1);
        for (int k = 0; k < 1000; k++) tick(k[0], 1'b0);
        check("freeze valid", out_valid, 0);
        check("freeze sample", out_sample, 0);
        check("freeze locked", locked, 1);
        repeat (60) tick(1'b1, 1'b1);
        repeat (95) tick(1'b0, 1'b1);
        check("freeze no early close", out_valid, 0);
        tick(1'b0, 1'b1);
        check("freeze close valid", out_valid, 1);
        check("freeze sample count", out_sample, 60);

        // Reset mid-window with a pending sample
        out_ready = 1'b0;
        repeat (120) tick(1'b1, 1'b1);
        check("pre-reset valid", out_valid, 1);
        rst_n = 1'b0;
        tick(1'b1, 1'b1);
        check("mid reset sample", out_sample, 0);
        check("mid reset valid", out_valid, 0);
        check("mid reset ovr", ovr_flag, 0);
        check("mid reset locked", locked, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        check_startup("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
